// File: rtl/semaforo_fsm_param_if.sv
// semaforo_fsm_param_if: sensor, button, night and lamp signals of one traffic-light approach
interface semaforo_fsm_param_if;
  logic CAR;
  logic PED;
  logic night;
  logic red;
  logic ylw;
  logic grn;
  logic walk;
  modport master (output CAR, PED, night, input red, ylw, grn, walk);
  modport slave (input CAR, PED, night, output red, ylw, grn, walk);
endinterface

// File: rtl/semaforo_fsm_param.sv
// semaforo_fsm_param: timed traffic light with latched car/pedestrian requests and flashing night mode
module semaforo_fsm_param #(
  parameter int W         = 8,
  parameter int T_GRN_MIN = 5,
  parameter int T_YLW     = 3,
  parameter int T_RED     = 10,
  parameter int T_FLASH   = 2
) (
  input logic Clock,
  input logic Reset,
  semaforo_fsm_param_if.slave io
);
  localparam int T_MAX = (1 << W) - 1;
  if (T_GRN_MIN < 1 || T_GRN_MIN > T_MAX || T_YLW < 1 || T_YLW > T_MAX ||
      T_RED < 1 || T_RED > T_MAX || T_FLASH < 1 || T_FLASH > T_MAX) begin : g_bad_params
    $fatal(1, "semaforo_fsm_param: phase durations must lie in 1 .. 2^W-1");
  end
  localparam logic [W-1:0] C_GMIN  = W'(T_GRN_MIN - 1);
  localparam logic [W-1:0] C_YLW   = W'(T_YLW - 1);
  localparam logic [W-1:0] C_RED   = W'(T_RED - 1);
  localparam logic [W-1:0] C_FLASH = W'(T_FLASH - 1);
  typedef enum logic [2:0] {GRN, YLW, RED, FL_ON, FL_OFF} state_t;
  state_t state, nxt;
  logic [W-1:0] cnt;
  logic car_pend, ped_pend, to_night;
  logic leave_red, leave_ylw, go_night;
  assign leave_red = state == RED && nxt == GRN;
  assign leave_ylw = state == YLW && nxt != YLW;
  assign go_night  = state == GRN && io.night;
  // state, phase counter (restarts on every state change, saturates) and request latches
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= GRN;
      cnt      <= '0;
      car_pend <= 1'b0;
      ped_pend <= 1'b0;
      to_night <= 1'b0;
    end else begin
      state    <= nxt;
      cnt      <= nxt != state ? '0 : (cnt != '1 ? cnt + W'(1) : cnt);
      car_pend <= io.CAR | (car_pend & ~leave_red);
      ped_pend <= io.PED | (ped_pend & ~leave_red);
      to_night <= go_night | (to_night & ~leave_ylw);
    end
  end
  // next state; night is only looked at in green and while flashing
  always_comb begin
    nxt = state;
    case (state)
      GRN:     nxt = (io.night || ((car_pend || ped_pend || io.CAR || io.PED) && cnt >= C_GMIN)) ? YLW : GRN;
      YLW:     nxt = cnt == C_YLW ? (to_night ? FL_ON : RED) : YLW;
      RED:     nxt = cnt == C_RED ? GRN : RED;
      FL_ON:   nxt = !io.night ? RED : (cnt == C_FLASH ? FL_OFF : FL_ON);
      FL_OFF:  nxt = !io.night ? RED : (cnt == C_FLASH ? FL_ON : FL_OFF);
      default: nxt = GRN;
    endcase
  end
  // Moore lamp decode
  always_comb begin
    io.red  = state == RED;
    io.ylw  = state == YLW || state == FL_ON;
    io.grn  = state == GRN;
    io.walk = state == RED && ped_pend;
  end
endmodule
